seg_scan_6: RTL

SEG_SCAN_6 -- requirements
Module: seg_scan_6

---
 rtl/seg_scan_6.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_6.sv
// Six-digit multiplexed seven-segment scanner.
// A prescaler sets how long each digit stays lit. The digit index steps 0..5.
// Inputs are captured once per frame, so one frame never shows a mix of old
// and new values. The active-low outputs are registered and have one cycle of latency.
module seg_scan_6 #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] digits,
  input  logic [5:0]  dp_in,
  input  logic        lz_en,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam logic [15:0] CntMax  = 16'(SCAN_DIV - 1);
  localparam logic [2:0]  LastIdx = 3'd5;

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] snap_dig_q, snap_dig_d;
  logic [5:0]  snap_dp_q, snap_dp_d;
  logic        snap_lz_q, snap_lz_d;
  logic [5:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_q, frame_d;

  logic        tick;
  logic        wrap;
  logic [5:0]  blank;
  logic [3:0]  cur_dig;
  logic        cur_dp;
  logic        cur_blank;
  logic        cur_valid;

  // BCD to active-low g..a pattern; non-decimal codes show a dash.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Prescaler, digit index and per-frame snapshot next-state.
  always_comb begin
    tick       = en && (cnt_q == CntMax);
    wrap       = tick && (idx_q == LastIdx);
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_lz_d  = snap_lz_q;
    frame_d    = wrap;
    if (en) begin
      cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end
    if (tick) begin
      idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    end
    if (wrap) begin
      snap_dig_d = digits;
      snap_dp_d  = dp_in;
      snap_lz_d  = lz_en;
    end
  end

  // Leading-zero blanking: digit k is blank when it and every digit above it are zero.
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int k = 5; k >= 1; k--) begin
      run      = run && (snap_dig_d[4*k +: 4] == 4'd0);
      blank[k] = snap_lz_d && run;
    end
  end

  // Select the digit being shown next. This is based on the next-state index and
  // snapshot, so the registered outputs line up with the tick.
  always_comb begin
    cur_dig   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    cur_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (idx_d == 3'(k)) begin
        cur_dig   = snap_dig_d[4*k +: 4];
        cur_dp    = snap_dp_d[k];
        cur_blank = blank[k];
        cur_valid = 1'b1;
      end
    end
  end

  // Output next-state: all-off while disabled or blanked.
  always_comb begin
    an_d  = 6'h3F;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en && cur_valid && !cur_blank) begin
      an_d  = ~(6'd1 << idx_d);
      seg_d = enc(cur_dig);
      dp_d  = ~cur_dp;
    end
  end

  // State and output registers; index resets to 5 so the first tick starts a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 16'd0;
      idx_q      <= LastIdx;
      snap_dig_q <= 24'd0;
      snap_dp_q  <= 6'd0;
      snap_lz_q  <= 1'b0;
      an_q       <= 6'h3F;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_lz_q  <= snap_lz_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule
